// File: rtl/serial_reg_bridge.sv
// Byte-protocol register bridge: serial command bytes in, register bus access, response byte out.
// Optional write-frame timeout is enabled by defining SERIAL_REG_BRIDGE_TIMEOUT_EN.
module serial_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       overrun,
    output logic       frame_err
);

    localparam logic [7:0] ACK = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_RD,
        S_CAP,
        S_TX
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [6:0] addr_nx;
    logic [7:0] wdata_nx;
    logic [7:0] tx_nx;
    logic       we_nx;
    logic       ovr_nx;
    logic       expired;

`ifdef SERIAL_REG_BRIDGE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Counter is held at zero outside WDATA, so it restarts on every write command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= (state == S_WDATA) && !new_rx_data && expired;
            if (state != S_WDATA)
                cnt <= '0;
            else if (!new_rx_data && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_LAST);
`else
    assign expired   = 1'b0;
    assign frame_err = 1'b0;
`endif

    assign reg_re      = (state == S_RD);
    assign new_tx_data = (state == S_TX) && !tx_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            reg_addr  <= '0;
            reg_wdata <= '0;
            tx_data   <= '0;
            reg_we    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            reg_addr  <= addr_nx;
            reg_wdata <= wdata_nx;
            tx_data   <= tx_nx;
            reg_we    <= we_nx;
            overrun   <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = reg_addr;
        wdata_nx = reg_wdata;
        tx_nx    = tx_data;
        we_nx    = 1'b0;
        ovr_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_rx_data) begin
                    addr_nx  = rx_data[6:0];
                    state_nx = rx_data[7] ? S_WDATA : S_RD;
                end
            end
            S_WDATA: begin
                // A byte arriving on the expiry cycle still counts as write data.
                if (new_rx_data) begin
                    wdata_nx = rx_data;
                    we_nx    = 1'b1;
                    tx_nx    = ACK;
                    state_nx = S_TX;
                end else if (expired) begin
                    state_nx = S_IDLE;
                end
            end
            S_RD: begin
                ovr_nx   = new_rx_data;
                state_nx = S_CAP;
            end
            S_CAP: begin
                ovr_nx   = new_rx_data;
                tx_nx    = reg_rdata;
                state_nx = S_TX;
            end
            S_TX: begin
                ovr_nx = new_rx_data;
                if (!tx_busy)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Self-checking bench for serial_reg_bridge: transaction-level reference model plus directed literal checks.
module tb_serial_reg_bridge;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = '0;
    logic       overrun;
    logic       frame_err;

    always #5 clk = ~clk;

    serial_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .overrun(overrun), .frame_err(frame_err)
    );

    // Register-bus slave: read data appears one cycle after reg_re.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) mem[reg_addr] = reg_wdata;
    end

    // Reference model: pending events are stored as absolute cycle numbers.
    int         cyc;
    bit [7:0]   ref_mem [128];
    bit         wait_data;
    int         wr_start, rd_at, we_at, ovr_at, ferr_at, tx_from, tx_chg;
    bit         tx_pend;
    bit [7:0]   tx_old, tx_new, m_wdata;
    bit [6:0]   m_addr;
    int         checks = 0;
    int         errors = 0;
    int         n_ovr, n_tx, n_ferr, n_we;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        wait_data = 1'b0;
        tx_pend   = 1'b0;
        rd_at = -1; we_at = -1; ovr_at = -1; ferr_at = -1;
        tx_from = 0; tx_chg = 0; wr_start = 0;
        tx_old = '0; tx_new = '0; m_wdata = '0; m_addr = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_new_tx"}, 8'(new_tx_data), 8'h00);
        chk({tag, "_addr"}, 8'(reg_addr), 8'h00);
        chk({tag, "_wdata"}, reg_wdata, 8'h00);
        chk({tag, "_we_re"}, {6'b0, reg_we, reg_re}, 8'h00);
        chk({tag, "_ovr_ferr"}, {6'b0, overrun, frame_err}, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; new_rx_data = 1'b0; rx_data = '0; tx_busy = 1'b0;
        @(negedge clk);
        check_zero("reset");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit busy);
        bit       fire, pend_now;
        bit [7:0] exp_tx;
        @(posedge clk); #1;
        cyc++;
        new_rx_data = v; rx_data = b; tx_busy = busy;
        @(negedge clk);
        fire   = tx_pend && (cyc >= tx_from) && !busy;
        exp_tx = (cyc >= tx_chg) ? tx_new : tx_old;
        chk("reg_re", 8'(reg_re), 8'(rd_at == cyc));
        chk("reg_we", 8'(reg_we), 8'(we_at == cyc));
        chk("reg_addr", 8'(reg_addr), 8'(m_addr));
        chk("reg_wdata", reg_wdata, m_wdata);
        chk("tx_data", tx_data, exp_tx);
        chk("new_tx_data", 8'(new_tx_data), 8'(fire));
        chk("overrun", 8'(overrun), 8'(ovr_at == cyc));
        chk("frame_err", 8'(frame_err), 8'(ferr_at == cyc));
        if (overrun) n_ovr++;
        if (new_tx_data) n_tx++;
        if (frame_err) n_ferr++;
        if (reg_we) n_we++;

        pend_now = tx_pend;
        if (fire) tx_pend = 1'b0;
        if (v) begin
            if (pend_now) begin
                ovr_at = cyc + 1;
            end else if (wait_data) begin
                wait_data = 1'b0;
                m_wdata   = b;
                we_at     = cyc + 1;
                ref_mem[m_addr] = b;
                tx_old = tx_new; tx_new = 8'h06; tx_chg = cyc + 1;
                tx_pend = 1'b1; tx_from = cyc + 1;
            end else begin
                m_addr = b[6:0];
                if (b[7]) begin
                    wait_data = 1'b1;
                    wr_start  = cyc + 1;
                end else begin
                    rd_at  = cyc + 1;
                    tx_old = tx_new; tx_new = ref_mem[b[6:0]]; tx_chg = cyc + 3;
                    tx_pend = 1'b1; tx_from = cyc + 3;
                end
            end
        end
`ifdef SERIAL_REG_BRIDGE_TIMEOUT_EN
        else if (wait_data && (cyc - wr_start == int'(TO) - 1)) begin
            wait_data = 1'b0;
            ferr_at   = cyc + 1;
        end
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cmd_cyc, ferr_cyc;
        bit v;
        rst = 1'b0; new_rx_data = 1'b0; rx_data = '0; tx_busy = 1'b0;
        cyc = 0;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[7'h12] = 8'h3C; ref_mem[7'h12] = 8'h3C;
        model_reset();
        do_reset();

        // Read of address 0x12
        step(1'b1, 8'h12, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_rd_re", 8'(reg_re), 8'h01);
        chk("lit_rd_addr", 8'(reg_addr), 8'h12);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_rd_new_tx", 8'(new_tx_data), 8'h01);
        chk("lit_rd_tx_data", tx_data, 8'h3C);
        step(1'b0, 8'h00, 1'b0);

        // Write 0xA7 to address 5
        step(1'b1, 8'h85, 1'b0);
        step(1'b1, 8'hA7, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_wr_we", 8'(reg_we), 8'h01);
        chk("lit_wr_addr", 8'(reg_addr), 8'h05);
        chk("lit_wr_wdata", reg_wdata, 8'hA7);
        chk("lit_wr_ack", tx_data, 8'h06);
        chk("lit_wr_new_tx", 8'(new_tx_data), 8'h01);
        step(1'b0, 8'h00, 1'b0);

        // Backpressure with a stray byte during the wait
        n_tx = 0; n_ovr = 0;
        step(1'b1, 8'h12, 1'b1);
        for (int i = 0; i < 100; i++) step(i == 50, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_bp_new_tx", 8'(new_tx_data), 8'h01);
        chk("lit_bp_tx_data", tx_data, 8'h3C);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_bp_tx_count", 8'(n_tx), 8'h01);
        chk("lit_bp_ovr_count", 8'(n_ovr), 8'h01);

        // Reset while waiting for write data, then a fresh read of address 5
        step(1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        do_reset();
        step(1'b1, 8'h05, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_rst_rd_re", 8'(reg_re), 8'h01);
        chk("lit_rst_rd_addr", 8'(reg_addr), 8'h05);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

        // Write command with no data byte
        n_ferr = 0; n_we = 0; n_tx = 0;
        step(1'b1, 8'h81, 1'b0);
        cmd_cyc = cyc;
`ifdef SERIAL_REG_BRIDGE_TIMEOUT_EN
        ferr_cyc = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (frame_err && ferr_cyc < 0) ferr_cyc = cyc;
        end
        chk("lit_to_ferr_count", 8'(n_ferr), 8'h01);
        chk("lit_to_ferr_delay", 8'(ferr_cyc - cmd_cyc), 8'd17);
        chk("lit_to_no_we", 8'(n_we), 8'h00);
        chk("lit_to_no_tx", 8'(n_tx), 8'h00);
`else
        ferr_cyc = 0;
        for (int i = 0; i < 1000; i++) step(1'b0, 8'h00, 1'b0);
        chk("lit_nto_ferr_count", 8'(n_ferr + ferr_cyc), 8'h00);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_nto_we", 8'(reg_we), 8'h01);
        chk("lit_nto_addr", 8'(reg_addr + 7'(cmd_cyc - cmd_cyc)), 8'h01);
        chk("lit_nto_wdata", reg_wdata, 8'h5A);
        step(1'b0, 8'h00, 1'b0);
        chk("lit_nto_we_count", 8'(n_we), 8'h01);
`endif

        // Randomized traffic: dense and sparse phases so some writes time out
        for (int i = 0; i < 3000; i++) begin
            if ((i % 600) < 300) v = ($urandom_range(0, 2) == 0);
            else                 v = ($urandom_range(0, 24) == 0);
            step(v, 8'($urandom), $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
